// File: rtl/dino_pkg.sv
// Shared definitions for the dino game obstacle path: cactus kinds and the
// spawner FSM state encoding.
package dino_pkg;

    localparam logic [1:0] KIND_SMALL  = 2'd0;
    localparam logic [1:0] KIND_DOUBLE = 2'd1;
    localparam logic [1:0] KIND_TALL   = 2'd2;
    localparam logic [1:0] KIND_TRIPLE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

endpackage

// File: rtl/cactus_spawner_slot_pick.sv
// Lowest-index free-slot priority encoder: isolates the lowest set bit of the
// free mask as a one-hot grant.
module slot_pick
    import dino_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] free,
    output logic [N-1:0] grant,
    output logic         any_free
);

    // Two's-complement trick: free & -free keeps only the lowest set bit.
    assign grant    = free & (~free + N'(1));
    assign any_free = |free;

endmodule

// File: rtl/cactus_spawner.sv
// Cactus obstacle scheduler: spawns obstacles at random gaps into a small slot
// pool, scrolls them left once per frame and retires them at the left edge.
module cactus_spawner
    import dino_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int X_WIDTH   = 10,
    parameter int X_START   = 640,
    parameter int SPEED     = 2,
    parameter int MIN_GAP   = 96
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_tick,
    input  logic                           run,
    input  logic                           crash,
    input  logic [4:0]                     rand_in,
    output logic [NUM_SLOTS-1:0]           slot_valid,
    output logic [NUM_SLOTS*X_WIDTH-1:0]   slot_x,
    output logic [NUM_SLOTS*2-1:0]         slot_kind,
    output logic                           spawn_pulse,
    output logic [1:0]                     state_o
);

    localparam logic [X_WIDTH-1:0] X_SPEED = X_WIDTH'(SPEED);
    localparam logic [X_WIDTH-1:0] X_SPAWN = X_WIDTH'(X_START);
    localparam logic [7:0]         G_SPEED = 8'(SPEED);
    localparam logic [7:0]         G_MIN   = 8'(MIN_GAP);

    state_t               state, state_nx;
    logic [X_WIDTH-1:0]   x_q    [NUM_SLOTS];
    logic [1:0]           kind_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q;
    logic [7:0]           gap_q;
    logic                 spawn_q;

    logic [NUM_SLOTS-1:0] expire, free_mask, grant;
    logic                 any_free, step, do_spawn;

    // Expiry is decided before the move so positions never underflow.
    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            expire[i] = valid_q[i] && (x_q[i] <= X_SPEED);
        end
        free_mask = ~(valid_q & ~expire);
    end

    slot_pick #(.N(NUM_SLOTS)) u_pick (
        .free     (free_mask),
        .grant    (grant),
        .any_free (any_free)
    );

    // A crash or a run drop in the same cycle as frame_tick suppresses the step.
    assign step     = (state == RUN) && run && !crash && frame_tick;
    assign do_spawn = step && (gap_q <= G_SPEED) && any_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (run) state_nx = RUN;
            RUN:     if (!run) state_nx = IDLE;
                     else if (crash) state_nx = FROZEN;
            FROZEN:  if (!run) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            gap_q   <= '0;
            spawn_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]    <= '0;
                kind_q[i] <= '0;
            end
        end else begin
            spawn_q <= 1'b0;
            if (state != IDLE && !run) begin
                valid_q <= '0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    x_q[i]    <= '0;
                    kind_q[i] <= '0;
                end
            end else if (state == IDLE && run) begin
                gap_q <= G_MIN;
            end else if (step) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (expire[i])       valid_q[i] <= 1'b0;
                    else if (valid_q[i]) x_q[i]     <= x_q[i] - X_SPEED;
                    if (do_spawn && grant[i]) begin
                        valid_q[i] <= 1'b1;
                        x_q[i]     <= X_SPAWN;
                        kind_q[i]  <= rand_in[1:0];
                    end
                end
                if (do_spawn) begin
                    spawn_q <= 1'b1;
                    gap_q   <= G_MIN + {1'b0, rand_in[4:2], 4'b0000};
                end else begin
                    gap_q <= (gap_q > G_SPEED) ? gap_q - G_SPEED : 8'd0;
                end
            end
        end
    end

    always_comb begin
        slot_x    = '0;
        slot_kind = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_x[i*X_WIDTH +: X_WIDTH] = x_q[i];
            slot_kind[i*2 +: 2]          = kind_q[i];
        end
    end

    assign slot_valid  = valid_q;
    assign spawn_pulse = spawn_q;
    assign state_o     = state;

endmodule

// File: tb/tb_cactus_spawner.sv
// Bench for cactus_spawner: SPEED=2 instance for spawn/scroll/crash/restart/reset,
// SPEED=1 instance for the full-pool case.
module tb_cactus_spawner;

    localparam int NS = 4;
    localparam int XW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Valid/ready rule here: spawn_pulse is a one-cycle valid with no back-pressure;
    // each pulse consumes exactly one expected entry {tick, slot, kind}.
    logic            frame_tick, run, crash;
    logic [4:0]      rand_in;
    logic [NS-1:0]   slot_valid;
    logic [NS*XW-1:0] slot_x;
    logic [NS*2-1:0] slot_kind;
    logic            spawn_pulse;
    logic [1:0]      state_o;

    logic            frame_tick1, run1, crash1;
    logic [4:0]      rand_in1;
    logic [NS-1:0]   slot_valid1;
    logic [NS*XW-1:0] slot_x1;
    logic [NS*2-1:0] slot_kind1;
    logic            spawn_pulse1;
    logic [1:0]      state_o1;

    cactus_spawner u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .crash(crash),
        .rand_in(rand_in), .slot_valid(slot_valid), .slot_x(slot_x),
        .slot_kind(slot_kind), .spawn_pulse(spawn_pulse), .state_o(state_o)
    );

    cactus_spawner #(.SPEED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick1), .run(run1), .crash(crash1),
        .rand_in(rand_in1), .slot_valid(slot_valid1), .slot_x(slot_x1),
        .slot_kind(slot_kind1), .spawn_pulse(spawn_pulse1), .state_o(state_o1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int tick_cnt   = 0;
    int tick_cnt1  = 0;

    logic [16:0] exp_q[$];
    logic [16:0] exp_q1[$];

    function automatic logic [16:0] ev(input int t, input int s, input int k);
        return {12'(t), 3'(s), 2'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            tick_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic tick1(input int n);
        repeat (n) begin
            frame_tick1 = 1'b1;
            @(posedge clk); #1;
            frame_tick1 = 1'b0;
            tick_cnt1++;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    logic [16:0] m_e;
    int          m_s;
    always @(negedge clk) begin
        if (rst_n && spawn_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_spawn: pulse at tick %0d, none expected", tick_cnt);
            end else begin
                m_e = exp_q.pop_front();
                m_s = int'(m_e[4:2]);
                check("spawn_tick", 64'(tick_cnt), 64'(m_e[16:5]));
                check("spawn_valid", 64'(slot_valid[m_s]), 64'd1);
                check("spawn_x", 64'(slot_x[m_s*XW +: XW]), 64'd640);
                check("spawn_kind", 64'(slot_kind[m_s*2 +: 2]), 64'(m_e[1:0]));
            end
        end
    end

    logic [16:0] m1_e;
    int          m1_s;
    always @(negedge clk) begin
        if (rst_n && spawn_pulse1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_spawn1: pulse at tick %0d, none expected", tick_cnt1);
            end else begin
                m1_e = exp_q1.pop_front();
                m1_s = int'(m1_e[4:2]);
                check("spawn1_tick", 64'(tick_cnt1), 64'(m1_e[16:5]));
                check("spawn1_valid", 64'(slot_valid1[m1_s]), 64'd1);
                check("spawn1_x", 64'(slot_x1[m1_s*XW +: XW]), 64'd640);
                check("spawn1_kind", 64'(slot_kind1[m1_s*2 +: 2]), 64'(m1_e[1:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        mismatched++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        frame_tick = 0; run = 0; crash = 0; rand_in = '0;
        frame_tick1 = 0; run1 = 0; crash1 = 0; rand_in1 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_valid", 64'(slot_valid), 64'd0);
        check("rst_x", 64'(slot_x), 64'd0);
        check("rst_kind", 64'(slot_kind), 64'd0);
        check("rst_pulse", 64'(spawn_pulse), 64'd0);
        check("rst_state1", 64'(state_o1), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First spawn; a frame_tick alongside the run rise must be ignored.
        rand_in = 5'b10110; run = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("state_run", 64'(state_o), 64'd1);
        check("idle_tick_ignored", 64'(slot_valid), 64'd0);
        @(posedge clk); #1;

        exp_q.push_back(ev(48, 0, 2));
        tick(48);
        rand_in = 5'b11111;
        exp_q.push_back(ev(136, 1, 3));
        tick(88);
        check("scroll_x0_136", 64'(slot_x[0*XW +: XW]), 64'd464);
        rand_in = 5'b01001;
        exp_q.push_back(ev(240, 2, 1));
        tick(104);
        rand_in = 5'b00000;
        exp_q.push_back(ev(304, 3, 0));
        tick(64);

        // Pool full at SPEED=2: gap reaches 0 at tick 352 and holds until slot 0 frees.
        tick(48);
        check("full_valid_352", 64'(slot_valid), 64'hF);
        tick(15);
        check("full_valid_367", 64'(slot_valid), 64'hF);
        check("x0_at_edge_367", 64'(slot_x[0*XW +: XW]), 64'd2);
        check("x1_367", 64'(slot_x[1*XW +: XW]), 64'd178);
        exp_q.push_back(ev(368, 0, 0));
        tick(1);
        check("refill_valid_368", 64'(slot_valid), 64'hF);
        check("x1_368", 64'(slot_x[1*XW +: XW]), 64'd176);
        tick(2);
        check("x0_370", 64'(slot_x[0*XW +: XW]), 64'd636);

        // Crash coincident with frame_tick: no move, freeze.
        crash = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        crash = 1'b0; frame_tick = 1'b0;
        check("crash_state", 64'(state_o), 64'd2);
        check("crash_x0", 64'(slot_x[0*XW +: XW]), 64'd636);
        check("crash_x1", 64'(slot_x[1*XW +: XW]), 64'd172);
        tick(5);
        check("frozen_x0", 64'(slot_x[0*XW +: XW]), 64'd636);
        check("frozen_valid", 64'(slot_valid), 64'hF);
        check("frozen_state", 64'(state_o), 64'd2);
        run = 1'b0;
        @(posedge clk); #1;
        check("stop_valid", 64'(slot_valid), 64'd0);
        check("stop_state", 64'(state_o), 64'd0);

        // Restart: gap reloads, first spawn again on tick 48.
        rand_in = 5'b00000; tick_cnt = 0; run = 1'b1;
        @(posedge clk); #1;
        check("restart_state", 64'(state_o), 64'd1);
        exp_q.push_back(ev(48, 0, 0));
        exp_q.push_back(ev(96, 1, 0));
        exp_q.push_back(ev(144, 2, 0));
        tick(150);
        check("restart_valid", 64'(slot_valid), 64'h7);
        check("restart_x0", 64'(slot_x[0*XW +: XW]), 64'd436);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(slot_valid), 64'd0);
        check("arst_x", 64'(slot_x), 64'd0);
        check("arst_kind", 64'(slot_kind), 64'd0);
        check("arst_state", 64'(state_o), 64'd0);
        check("arst_pulse", 64'(spawn_pulse), 64'd0);
        run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SPEED=1 instance: four spawns fill the pool, then one lands on slot 0's expiry.
        run1 = 1'b1;
        @(posedge clk); #1;
        exp_q1.push_back(ev(96, 0, 0));
        exp_q1.push_back(ev(192, 1, 0));
        exp_q1.push_back(ev(288, 2, 0));
        exp_q1.push_back(ev(384, 3, 0));
        tick1(384);
        check("s1_full_384", 64'(slot_valid1), 64'hF);
        tick1(96);
        check("s1_full_480", 64'(slot_valid1), 64'hF);
        tick1(255);
        check("s1_full_735", 64'(slot_valid1), 64'hF);
        check("s1_x0_735", 64'(slot_x1[0*XW +: XW]), 64'd1);
        exp_q1.push_back(ev(736, 0, 0));
        tick1(1);
        check("s1_x1_736", 64'(slot_x1[1*XW +: XW]), 64'd96);
        check("s1_valid_736", 64'(slot_valid1), 64'hF);

        @(posedge clk); #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
